sfx_tone_mux: RTL

Audio arbitration stage between the background-music tone lookup and the PWM generator. Each cycle it selects whether the PWM generator sees the current music tone or a game sound effect. Sound effects are jump, spring and fall pitch sweeps, each with a fixed priority. The block also applies mute and a 3-bit volume to the duty output. Its outputs drive the PWM generator's `freq` and `duty` inputs directly.

---
 rtl/audio_pkg.sv | 56 +++++
 rtl/sfx_step_timer.sv | 27 ++
 rtl/sfx_tone_mux.sv | 98 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants: rest frequency, effect sweep tables and duty scaling.
package audio_pkg;

    localparam logic [31:0] SILENCE_FREQ = 32'd50_000_000;

    localparam int unsigned DUTY_SHIFT_MUSIC = 6;
    localparam int unsigned DUTY_SHIFT_SFX   = 7;

    // Encoding doubles as priority: a larger value outranks a smaller one.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StJump   = 2'd1,
        StSpring = 2'd2,
        StFall   = 2'd3
    } sfx_state_t;

    localparam logic [31:0] JUMP_START   = 32'd400;
    localparam logic [31:0] SPRING_START = 32'd600;
    localparam logic [31:0] FALL_START   = 32'd800;

    localparam logic signed [31:0] JUMP_STEP   = 32'sd40;
    localparam logic signed [31:0] SPRING_STEP = 32'sd80;
    localparam logic signed [31:0] FALL_STEP   = -32'sd25;

    localparam logic [4:0] JUMP_COUNT   = 5'd8;
    localparam logic [4:0] SPRING_COUNT = 5'd12;
    localparam logic [4:0] FALL_COUNT   = 5'd24;

    function automatic logic [31:0] sfx_start(sfx_state_t s);
        case (s)
            StJump:   return JUMP_START;
            StSpring: return SPRING_START;
            StFall:   return FALL_START;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic signed [31:0] sfx_step(sfx_state_t s);
        case (s)
            StJump:   return JUMP_STEP;
            StSpring: return SPRING_STEP;
            StFall:   return FALL_STEP;
            default:  return 32'sd0;
        endcase
    endfunction

    function automatic logic [4:0] sfx_count(sfx_state_t s);
        case (s)
            StJump:   return JUMP_COUNT;
            StSpring: return SPRING_COUNT;
            StFall:   return FALL_COUNT;
            default:  return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/sfx_step_timer.sv
// Sweep step timer: counts 0..STEP_CYCLES-1 while running and flags the terminal count.
module sfx_step_timer #(
    parameter int unsigned STEP_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic step_tick
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign step_tick = run && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || !run || step_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sfx_tone_mux.sv
// Selects music tone or a prioritised sound-effect sweep for the PWM generator,
// applying mute and volume to the duty output.
module sfx_tone_mux
    import audio_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] music_tone,
    input  logic        jump_pulse,
    input  logic        spring_pulse,
    input  logic        fall_pulse,
    input  logic        mute,
    input  logic [2:0]  volume,
    output logic [31:0] freq,
    output logic [9:0]  duty,
    output logic        sfx_active
);

    sfx_state_t  state_q, state_d, req;
    logic [31:0] sweep_q, sweep_d;
    logic [4:0]  index_q, index_d;
    logic        restart, step_tick;
    logic [31:0] freq_d;
    logic [9:0]  duty_d;

    sfx_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart),
        .run      (state_q != StIdle),
        .step_tick(step_tick)
    );

    always_comb begin
        if (fall_pulse)        req = StFall;
        else if (spring_pulse) req = StSpring;
        else if (jump_pulse)   req = StJump;
        else                   req = StIdle;
    end

    // Equal priority restarts; lower priority is dropped, not queued.
    assign restart = (req != StIdle) && (req >= state_q);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        index_d = index_q;
        if (restart) begin
            state_d = req;
            sweep_d = sfx_start(req);
            index_d = '0;
        end else if (step_tick) begin
            if (index_q == sfx_count(state_q) - 5'd1) begin
                state_d = StIdle;
                index_d = '0;
            end else begin
                sweep_d = sweep_q + sfx_step(state_q);
                index_d = index_q + 5'd1;
            end
        end
    end

    // Output stage is fed from next-state so a trigger is visible one cycle later.
    always_comb begin
        freq_d = (state_d == StIdle) ? music_tone : sweep_d;
        if (mute || volume == 3'd0) begin
            duty_d = '0;
        end else if (state_d == StIdle) begin
            duty_d = (music_tone == SILENCE_FREQ) ? 10'd0
                                                   : ({7'd0, volume} << DUTY_SHIFT_MUSIC);
        end else begin
            duty_d = {7'd0, volume} << DUTY_SHIFT_SFX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sweep_q    <= '0;
            index_q    <= '0;
            freq       <= SILENCE_FREQ;
            duty       <= '0;
            sfx_active <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            index_q    <= index_d;
            freq       <= freq_d;
            duty       <= duty_d;
            sfx_active <= (state_d != StIdle);
        end
    end

endmodule
